// File: rtl/mbox_pkg.sv
// Shared constants for the inter-core mailbox: register map, STATUS layout, side naming.
package mbox_pkg;

    // Register offsets within a 256-byte per-core window (addr[7:0]).
    localparam logic [7:0] MBOX_TXDATA = 8'h00;
    localparam logic [7:0] MBOX_RXDATA = 8'h04;
    localparam logic [7:0] MBOX_STATUS = 8'h08;
    localparam logic [7:0] MBOX_IRQ_EN = 8'h0C;
    localparam logic [7:0] MBOX_FLUSH  = 8'h10;

    // STATUS register field positions.
    localparam int unsigned STATUS_RX_EMPTY_BIT = 0;
    localparam int unsigned STATUS_TX_FULL_BIT  = 1;
    localparam int unsigned STATUS_RX_COUNT_LSB = 8;
    localparam int unsigned STATUS_TX_COUNT_LSB = 16;

    // Width of the occupancy counts reported in STATUS.
    localparam int unsigned COUNT_W = 8;

    // Which core's view a request is addressed to (addr[8]).
    typedef enum logic {
        SideCore0 = 1'b0,
        SideCore1 = 1'b1
    } side_e;

endpackage

// File: rtl/mbox_fifo.sv
// One-way message FIFO with wrap-bit pointers, head-of-queue output and a flush.
module mbox_fifo
    import mbox_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push,
    input  logic [Width-1:0]   wdata,
    input  logic               pop,
    input  logic               flush,
    output logic [Width-1:0]   rdata,
    output logic               empty,
    output logic               full,
    output logic [COUNT_W-1:0] count
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned PtrW = IdxW + 1;

    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;
    logic [PtrW-1:0]  used;
    logic [Width-1:0] mem [Depth];

    // Pointer update: push advances the write side, flush drops everything unread.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PtrW'(1);
            end
            if (flush) begin
                rptr <= wptr;
            end else if (pop) begin
                rptr <= rptr + PtrW'(1);
            end
        end
    end

    // Message storage.
    // NOTE: the array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr[IdxW-1:0]] <= wdata;
        end
    end

    assign used  = wptr - rptr;
    assign rdata = mem[rptr[IdxW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[PtrW-1] != rptr[PtrW-1]) && (wptr[IdxW-1:0] == rptr[IdxW-1:0]);
    assign count = COUNT_W'(used);

endmodule

// File: rtl/ibex_mailbox.sv
// Dual-core mailbox device: two one-way FIFOs behind per-core register windows.
module ibex_mailbox
    import mbox_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned Depth        = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mbox_req_i,
    input  logic                    mbox_we_i,
    input  logic [3:0]              mbox_be_i,
    input  logic [AddressWidth-1:0] mbox_addr_i,
    input  logic [DataWidth-1:0]    mbox_wdata_i,
    output logic                    mbox_rvalid_o,
    output logic [DataWidth-1:0]    mbox_rdata_o,
    output logic                    mbox_err_o,
    output logic [1:0]              mbox_irq_o
);

    // Fifo g carries messages sent by core g to the other core.
    logic [1:0]           push;
    logic [1:0]           pop;
    logic [1:0]           flush;
    logic [1:0]           empty;
    logic [1:0]           full;
    logic [DataWidth-1:0] head  [2];
    logic [COUNT_W-1:0]   count [2];

    logic [1:0]           irq_en;
    logic                 irq_en_we;
    logic                 rsp_err;
    logic [DataWidth-1:0] rsp_rdata;

    side_e                side;
    logic                 tx_idx;
    logic                 rx_idx;
    logic [7:0]           offset;
    logic                 bad_align;
    logic                 unused_addr;

    assign side      = side_e'(mbox_addr_i[8]);
    assign tx_idx    = side;
    assign rx_idx    = ~tx_idx;
    assign offset    = mbox_addr_i[7:0];
    assign bad_align = mbox_addr_i[9] || (mbox_addr_i[1:0] != 2'b00);

    // Bits above the window select belong to the bus decoder, not this device.
    assign unused_addr = ^mbox_addr_i[AddressWidth-1:10];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        mbox_fifo #(
            .Width (DataWidth),
            .Depth (Depth)
        ) u_fifo (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .push  (push[g]),
            .wdata (mbox_wdata_i),
            .pop   (pop[g]),
            .flush (flush[g]),
            .rdata (head[g]),
            .empty (empty[g]),
            .full  (full[g]),
            .count (count[g])
        );
    end

    // Request decode: FIFO strobes, IRQ_EN write strobe and the response payload.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        push      = '0;
        pop       = '0;
        flush     = '0;
        irq_en_we = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        if (mbox_req_i) begin
            if (bad_align) begin
                rsp_err = 1'b1;
            end else begin
                unique case (offset)
                    MBOX_TXDATA: begin
                        if (!mbox_we_i || mbox_be_i != 4'hF || full[tx_idx]) rsp_err = 1'b1;
                        else                                                 push[tx_idx] = 1'b1;
                    end
                    MBOX_RXDATA: begin
                        if (mbox_we_i || empty[rx_idx]) begin
                            rsp_err = 1'b1;
                        end else begin
                            pop[rx_idx] = 1'b1;
                            rsp_rdata   = head[rx_idx];
                        end
                    end
                    MBOX_STATUS: begin
                        if (mbox_we_i) begin
                            rsp_err = 1'b1;
                        end else begin
                            rsp_rdata[STATUS_RX_EMPTY_BIT] = empty[rx_idx];
                            rsp_rdata[STATUS_TX_FULL_BIT]  = full[tx_idx];
                            rsp_rdata[STATUS_RX_COUNT_LSB +: COUNT_W] = count[rx_idx];
                            rsp_rdata[STATUS_TX_COUNT_LSB +: COUNT_W] = count[tx_idx];
                        end
                    end
                    MBOX_IRQ_EN: begin
                        if (mbox_we_i) irq_en_we    = 1'b1;
                        else           rsp_rdata[0] = irq_en[tx_idx];
                    end
                    MBOX_FLUSH: begin
                        if (!mbox_we_i) rsp_err       = 1'b1;
                        else            flush[rx_idx] = mbox_wdata_i[0];
                    end
                    default: rsp_err = 1'b1;
                endcase
            end
        end
    end

    // Per-core interrupt enable, written through that core's own window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en <= '0;
        end else if (irq_en_we) begin
            irq_en[tx_idx] <= mbox_wdata_i[0];
        end
    end

    // Single-cycle response pipeline plus the registered software interrupts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mbox_rvalid_o <= 1'b0;
            mbox_rdata_o  <= '0;
            mbox_err_o    <= 1'b0;
            mbox_irq_o    <= '0;
        end else begin
            mbox_rvalid_o <= mbox_req_i;
            mbox_rdata_o  <= rsp_rdata;
            mbox_err_o    <= rsp_err;
            mbox_irq_o[0] <= irq_en[0] & ~empty[1];
            mbox_irq_o[1] <= irq_en[1] & ~empty[0];
        end
    end

endmodule

// File: tb/tb_ibex_mailbox.sv
// Self-checking bench for ibex_mailbox: directed scenarios plus random traffic against a queue model.
module tb_ibex_mailbox;

    localparam int unsigned DEPTH = 8;

    logic        clk_i;
    logic        rst_i;
    logic        mbox_req_i;
    logic        mbox_we_i;
    logic [3:0]  mbox_be_i;
    logic [31:0] mbox_addr_i;
    logic [31:0] mbox_wdata_i;
    logic        mbox_rvalid_o;
    logic [31:0] mbox_rdata_o;
    logic        mbox_err_o;
    logic [1:0]  mbox_irq_o;

    int total;
    int bad;

    // Reference model: q0 holds core0->core1 messages, q1 holds core1->core0.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [1:0]  m_en;

    ibex_mailbox #(
        .DataWidth    (32),
        .AddressWidth (32),
        .Depth        (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mbox_req_i    (mbox_req_i),
        .mbox_we_i     (mbox_we_i),
        .mbox_be_i     (mbox_be_i),
        .mbox_addr_i   (mbox_addr_i),
        .mbox_wdata_i  (mbox_wdata_i),
        .mbox_rvalid_o (mbox_rvalid_o),
        .mbox_rdata_o  (mbox_rdata_o),
        .mbox_err_o    (mbox_err_o),
        .mbox_irq_o    (mbox_irq_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tx_len(input logic s);
        return s ? q1.size() : q0.size();
    endfunction

    function automatic int rx_len(input logic s);
        return s ? q0.size() : q1.size();
    endfunction

    // Interrupt each core should see after the next edge, from the current model state.
    function automatic logic [1:0] model_irq();
        return {m_en[1] & (q0.size() != 0), m_en[0] & (q1.size() != 0)};
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_en = '0;
    endtask

    // Apply one bus access to the model and return the response it must produce.
    task automatic model_access(input logic we, input logic [3:0] be, input logic [9:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd);
        logic s;
        s   = a[8];
        err = 1'b0;
        rd  = '0;
        if (a[9] || a[1:0] != 2'b00) begin
            err = 1'b1;
        end else begin
            case (a[7:0])
                8'h00: begin
                    if (!we || be != 4'hF || tx_len(s) >= DEPTH) err = 1'b1;
                    else if (s) q1.push_back(wd);
                    else        q0.push_back(wd);
                end
                8'h04: begin
                    if (we || rx_len(s) == 0) err = 1'b1;
                    else if (s) rd = q0.pop_front();
                    else        rd = q1.pop_front();
                end
                8'h08: begin
                    if (we) begin
                        err = 1'b1;
                    end else begin
                        rd[0]     = (rx_len(s) == 0);
                        rd[1]     = (tx_len(s) == DEPTH);
                        rd[15:8]  = 8'(rx_len(s));
                        rd[23:16] = 8'(tx_len(s));
                    end
                end
                8'h0C: begin
                    if (we) m_en[s] = wd[0];
                    else    rd[0]   = m_en[s];
                end
                8'h10: begin
                    if (!we)       err = 1'b1;
                    else if (wd[0]) begin
                        if (s) q0.delete();
                        else   q1.delete();
                    end
                end
                default: err = 1'b1;
            endcase
        end
    endtask

    // One bus transaction, issued at posedge+1 and checked at the following posedge+1.
    task automatic bus(input logic we, input logic [3:0] be, input logic [9:0] a,
                       input logic [31:0] wd, output logic [31:0] rd);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [1:0]  exp_irq;
        exp_irq = model_irq();
        model_access(we, be, a, wd, exp_err, exp_rd);
        mbox_req_i   = 1'b1;
        mbox_we_i    = we;
        mbox_be_i    = be;
        mbox_addr_i  = {22'b0, a};
        mbox_wdata_i = wd;
        @(posedge clk_i);
        #1;
        mbox_req_i = 1'b0;
        mbox_we_i  = 1'b0;
        check("rvalid", 32'(mbox_rvalid_o), 32'd1);
        check("err", 32'(mbox_err_o), 32'(exp_err));
        check("rdata", mbox_rdata_o, exp_rd);
        check("irq", 32'(mbox_irq_o), 32'(exp_irq));
        rd = mbox_rdata_o;
    endtask

    task automatic idle(input int n);
        logic [1:0] exp_irq;
        for (int i = 0; i < n; i++) begin
            exp_irq = model_irq();
            @(posedge clk_i);
            #1;
            check("idle_rvalid", 32'(mbox_rvalid_o), 32'd0);
            check("idle_irq", 32'(mbox_irq_o), 32'(exp_irq));
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] words [DEPTH];
        total        = 0;
        bad          = 0;
        rst_i        = 1'b1;
        mbox_req_i   = 1'b0;
        mbox_we_i    = 1'b0;
        mbox_be_i    = 4'h0;
        mbox_addr_i  = '0;
        mbox_wdata_i = '0;
        model_reset();

        // Reset values.
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_rvalid", 32'(mbox_rvalid_o), 32'd0);
        check("rst_rdata", mbox_rdata_o, 32'd0);
        check("rst_err", 32'(mbox_err_o), 32'd0);
        check("rst_irq", 32'(mbox_irq_o), 32'd0);
        rst_i = 1'b0;
        idle(1);

        // Basic core0 -> core1 message.
        bus(1'b1, 4'hF, 10'h000, 32'hA5A5_0001, rd);
        bus(1'b0, 4'hF, 10'h104, 32'h0, rd);
        check("basic_pop", rd, 32'hA5A5_0001);
        bus(1'b0, 4'hF, 10'h108, 32'h0, rd);
        check("basic_empty", 32'(rd[0]), 32'd1);
        check("basic_count", 32'(rd[15:8]), 32'd0);

        // Fill core1 -> core0 to capacity, overflow, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = $urandom;
            bus(1'b1, 4'hF, 10'h100, words[i], rd);
        end
        bus(1'b1, 4'hF, 10'h100, 32'hDEAD_BEEF, rd);
        check("overflow_err", 32'(mbox_err_o), 32'd1);
        bus(1'b0, 4'hF, 10'h108, 32'h0, rd);
        check("full_txcount", 32'(rd[23:16]), DEPTH);
        check("full_flag", 32'(rd[1]), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            bus(1'b0, 4'hF, 10'h004, 32'h0, rd);
            check("drain_order", rd, words[i]);
        end

        // Interrupt to core1 follows its rx FIFO occupancy.
        bus(1'b1, 4'hF, 10'h10C, 32'h1, rd);
        bus(1'b1, 4'hF, 10'h000, 32'h0000_1234, rd);
        check("irq_not_yet", 32'(mbox_irq_o), 32'd0);
        idle(1);
        check("irq1_rise", 32'(mbox_irq_o), 32'b10);
        bus(1'b0, 4'hF, 10'h104, 32'h0, rd);
        check("irq_pop_data", rd, 32'h0000_1234);
        check("irq_still_up", 32'(mbox_irq_o), 32'b10);
        idle(1);
        check("irq1_fall", 32'(mbox_irq_o), 32'd0);

        // Error responses.
        bus(1'b0, 4'hF, 10'h004, 32'h0, rd);
        bus(1'b1, 4'h3, 10'h000, 32'h1111_2222, rd);
        check("partial_be_err", 32'(mbox_err_o), 32'd1);
        bus(1'b0, 4'hF, 10'h108, 32'h0, rd);
        check("partial_be_count", 32'(rd[23:16]), 32'd0);
        bus(1'b0, 4'hF, 10'h014, 32'h0, rd);
        bus(1'b1, 4'hF, 10'h202, 32'h0, rd);
        bus(1'b1, 4'hF, 10'h008, 32'h0, rd);
        bus(1'b0, 4'hF, 10'h010, 32'h0, rd);

        // Flush from the receiving side.
        for (int i = 0; i < 3; i++) bus(1'b1, 4'hF, 10'h000, $urandom, rd);
        idle(1);
        check("flush_irq_up", 32'(mbox_irq_o), 32'b10);
        bus(1'b1, 4'hF, 10'h110, 32'h1, rd);
        bus(1'b0, 4'hF, 10'h108, 32'h0, rd);
        check("flush_rxcount", 32'(rd[15:8]), 32'd0);
        check("flush_irq_down", 32'(mbox_irq_o), 32'd0);

        // Asynchronous reset with a response outstanding and a request in flight.
        bus(1'b1, 4'hF, 10'h000, 32'h0BAD_0001, rd);
        mbox_req_i   = 1'b1;
        mbox_we_i    = 1'b1;
        mbox_be_i    = 4'hF;
        mbox_addr_i  = 32'h000;
        mbox_wdata_i = 32'h0BAD_0002;
        @(posedge clk_i);
        #1;
        check("pre_rst_rvalid", 32'(mbox_rvalid_o), 32'd1);
        check("pre_rst_irq", 32'(mbox_irq_o), 32'b10);
        mbox_we_i   = 1'b0;
        mbox_addr_i = 32'h104;
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_squash_rvalid", 32'(mbox_rvalid_o), 32'd0);
        check("rst_squash_irq", 32'(mbox_irq_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        mbox_req_i = 1'b0;
        model_reset();
        check("rst_no_rsp", 32'(mbox_rvalid_o), 32'd0);
        idle(1);
        bus(1'b0, 4'hF, 10'h108, 32'h0, rd);
        bus(1'b0, 4'hF, 10'h008, 32'h0, rd);
        bus(1'b0, 4'hF, 10'h10C, 32'h0, rd);
        check("rst_irq_en", rd, 32'd0);

        // Random traffic from both cores, back to back with occasional gaps.
        for (int n = 0; n < 400; n++) begin
            logic       s;
            logic [9:0] base;
            int         op;
            s    = 1'($urandom_range(0, 1));
            base = {1'b0, s, 8'h00};
            op   = $urandom_range(0, 11);
            case (op)
                0, 1, 2: bus(1'b1, ($urandom_range(0, 7) == 0) ? 4'h3 : 4'hF, base | 10'h000, $urandom, rd);
                3, 4, 5: bus(1'b0, 4'hF, base | 10'h004, 32'h0, rd);
                6:       bus(1'b0, 4'hF, base | 10'h008, 32'h0, rd);
                7:       bus(1'b1, 4'hF, base | 10'h00C, $urandom, rd);
                8:       bus(1'b0, 4'hF, base | 10'h00C, 32'h0, rd);
                9:       bus(1'b1, 4'hF, base | 10'h010, ($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0, rd);
                10:      bus(1'($urandom_range(0, 1)), 4'hF, 10'($urandom), $urandom, rd);
                default: idle($urandom_range(1, 2));
            endcase
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
